// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, sequential framebuffer reads and RGB332 to 4:4:4 expansion.
// Define VGA_TEST_PATTERN_EN to add a pattern_sel input that replaces RAM colour with 8 bars.

module vga_scanout #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int RD_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic        rd_en,
    output logic [18:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        active,
    output logic        frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
    localparam logic [9:0] H_LAST_VIS = 10'(H_VIS - 1);
    localparam logic [9:0] V_LAST_VIS = 10'(V_VIS - 1);
    localparam logic [9:0] HS_BEG     = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG     = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON    = (SYNC_POL != 0);
    localparam logic       SYNC_OFF   = ~SYNC_ON;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
`ifdef VGA_TEST_PATTERN_EN
        logic [9:0] x;
`endif
    } stage_t;

    localparam stage_t STAGE_IDLE = stage_t'({SYNC_OFF, SYNC_OFF, 1'b0
`ifdef VGA_TEST_PATTERN_EN
        , 10'd0
`endif
    });

    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_nx;
    logic [9:0] v_nx;
    logic       wrap_line;
    logic       wrap_frame;
    logic       vis;
    logic       last_pix;
    stage_t     stage0;
    stage_t     feed;
    logic [3:0] red_nx;
    logic [3:0] green_nx;
    logic [3:0] blue_nx;

    always_comb begin
        wrap_line  = (h == H_LAST);
        wrap_frame = wrap_line && (v == V_LAST);
        h_nx       = wrap_line ? 10'd0 : h + 10'd1;
        v_nx       = v;
        if (wrap_line) begin
            v_nx = (v == V_LAST) ? 10'd0 : v + 10'd1;
        end
        vis      = (h < H_VIS_W) && (v < V_VIS_W);
        last_pix = (h == H_LAST_VIS) && (v == V_LAST_VIS);
    end

    // rd_en/rd_addr are computed from the next position so they describe the counters they
    // are registered alongside; the address is stepped rather than multiplied out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= '0;
            v           <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && wrap_frame;
            if (pix_en) begin
                h     <= h_nx;
                v     <= v_nx;
                rd_en <= (h_nx < H_VIS_W) && (v_nx < V_VIS_W);
                if (wrap_frame) begin
                    rd_addr <= '0;
                end else if (vis && !last_pix) begin
                    rd_addr <= rd_addr + 19'd1;
                end
            end
        end
    end

    always_comb begin
        stage0     = STAGE_IDLE;
        stage0.hs  = (h >= HS_BEG && h <= HS_END) ? SYNC_ON : SYNC_OFF;
        stage0.vs  = (v >= VS_BEG && v <= VS_END) ? SYNC_ON : SYNC_OFF;
        stage0.act = vis;
`ifdef VGA_TEST_PATTERN_EN
        stage0.x   = h;
`endif
    end

    // The output register is the last delay stage, so only RD_LAT-1 stages live here.
    generate
        if (RD_LAT == 2) begin : g_lat2
            stage_t mid;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mid <= STAGE_IDLE;
                end else if (pix_en) begin
                    mid <= stage0;
                end
            end
            assign feed = mid;
        end else begin : g_lat1
            assign feed = stage0;
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VIS / 8);
    logic [2:0] bar;
`endif

    always_comb begin
        red_nx   = '0;
        green_nx = '0;
        blue_nx  = '0;
`ifdef VGA_TEST_PATTERN_EN
        bar      = 3'(feed.x / BAR_W);
`endif
        if (feed.act) begin
`ifdef VGA_TEST_PATTERN_EN
            // Bar index bits map straight to inverted {G,R,B}: white..black in 8 steps.
            if (pattern_sel) begin
                red_nx   = {4{~bar[1]}};
                green_nx = {4{~bar[2]}};
                blue_nx  = {4{~bar[0]}};
            end else
`endif
            begin
                red_nx   = {rd_data[7:5], rd_data[7]};
                green_nx = {rd_data[4:2], rd_data[4]};
                blue_nx  = {rd_data[1:0], rd_data[1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync  <= SYNC_OFF;
            vsync  <= SYNC_OFF;
            active <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (pix_en) begin
            hsync  <= feed.hs;
            vsync  <= feed.vs;
            active <= feed.act;
            red    <= red_nx;
            green  <= green_nx;
            blue   <= blue_nx;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a shortened vertical frame keeps the run small while
// horizontal timing stays at full 800-tick lines.

module tb_vga_scanout;

    localparam int RD_LAT    = 2;
    localparam int H_VIS     = 640;
    localparam int H_TOT     = 800;
    localparam int V_VIS     = 4;
    localparam int V_TOT     = 8;
    localparam int HS_BEG    = 656;
    localparam int HS_END    = 751;
    localparam int VS_BEG    = 5;
    localparam int VS_END    = 6;
    localparam int LAST_ADDR = 2559;

    localparam logic [11:0] HAND [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'h99A};
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};
    localparam logic [14:0] PIX_IDLE = {1'b1, 1'b1, 1'b0, 12'h000};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic        rd_en;
    logic [18:0] rd_addr;
    logic [7:0]  rd_data;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        active;
    logic        frame_start;
    logic        psel;

    logic [7:0]  mem [0:4095];
    logic [7:0]  ram_q;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          eh;
    int          ev;
    logic [14:0] pix_q [$];
    logic [20:0] imm_q [$];
    logic [14:0] last_pix;
    logic [20:0] last_imm;
    logic [20:0] popped_imm;
    logic        tick;

    always #5 clk = ~clk;

    vga_scanout #(
        .V_VIS (V_VIS),
        .V_FP  (1),
        .V_SYNC(2),
        .V_BP  (1),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(psel),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .active     (active),
        .frame_start(frame_start)
    );

    // One registered stage plus the DUT colour register gives the two-tick read latency.
    always @(posedge clk) begin
        if (pix_en) ram_q <= mem[rd_addr[11:0]];
    end
    assign rd_data = ram_q;

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    function automatic logic [14:0] exp_pix(input int h, input int v, input logic pat);
        logic        hs;
        logic        vs;
        logic        act;
        logic [11:0] col;
        int          addr;
        hs  = (h >= HS_BEG && h <= HS_END) ? 1'b0 : 1'b1;
        vs  = (v >= VS_BEG && v <= VS_END) ? 1'b0 : 1'b1;
        act = (h < H_VIS) && (v < V_VIS);
        col = 12'h000;
        if (act) begin
            addr = v * H_VIS + h;
            if (pat)           col = BARS[h / 80];
            else if (addr < 4) col = HAND[addr];
            else               col = expand(mem[addr]);
        end
        return {hs, vs, act, col};
    endfunction

    function automatic logic [20:0] exp_imm(input int h, input int v, input logic fs);
        logic en;
        int   addr;
        en = (h < H_VIS) && (v < V_VIS);
        if (en)                addr = v * H_VIS + h;
        else if (v < V_VIS - 1) addr = (v + 1) * H_VIS;
        else                   addr = LAST_ADDR;
        return {en, fs, 19'(addr)};
    endfunction

    task automatic finishRun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h at %0t", name, act, exp, $time);
            if (n_fail >= 40) finishRun();
        end
    endtask

    // Monitor: on a tick pop the next expected response, otherwise everything must hold.
    always @(posedge clk) begin
        if (rst_n) begin
            tick = pix_en;
            #1;
            if (tick) begin
                if (pix_q.size() == 0 || imm_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL queue_underflow: got empty required entry at %0t", $time);
                end else begin
                    last_pix   = pix_q.pop_front();
                    popped_imm = imm_q.pop_front();
                    checkOutput("imm", 32'({rd_en, frame_start, rd_addr}), 32'(popped_imm));
                    last_imm   = {popped_imm[20], 1'b0, popped_imm[18:0]};
                end
            end else begin
                checkOutput("imm_hold", 32'({rd_en, frame_start, rd_addr}), 32'(last_imm));
            end
            checkOutput("pix", 32'({hsync, vsync, active, red, green, blue}), 32'(last_pix));
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        pix_en = 1'b0;
        #1;
        checkOutput("reset_imm", 32'({rd_en, frame_start, rd_addr}), 32'(0));
        checkOutput("reset_pix", 32'({hsync, vsync, active, red, green, blue}), 32'(PIX_IDLE));
        repeat (3) @(negedge clk);
        pix_q.delete();
        imm_q.delete();
        eh = 0;
        ev = 0;
        for (int i = 0; i < RD_LAT - 1; i++) pix_q.push_back(PIX_IDLE);
        last_pix = PIX_IDLE;
        last_imm = '0;
        rst_n    = 1'b1;
    endtask

    task automatic applyStimulus(input int n_ticks, input int spacing);
        logic wrap;
        for (int i = 0; i < n_ticks; i++) begin
            for (int k = 1; k < spacing; k++) begin
                @(negedge clk);
                pix_en = 1'b0;
            end
            @(negedge clk);
            pix_q.push_back(exp_pix(eh, ev, psel));
            wrap = (eh == H_TOT - 1) && (ev == V_TOT - 1);
            if (eh == H_TOT - 1) begin
                eh = 0;
                ev = (ev == V_TOT - 1) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
            imm_q.push_back(exp_imm(eh, ev, wrap));
            pix_en = 1'b1;
        end
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b0;
        psel   = 1'b0;
        ram_q  = 8'h00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'hE0;
        mem[1] = 8'h1C;
        mem[2] = 8'h03;
        mem[3] = 8'h92;

        $display("[TB] reset, then mid-line reset");
        doReset();
        applyStimulus(300, 1);
        doReset();
`ifdef VGA_TEST_PATTERN_EN
        $display("[TB] colour bar pattern");
        psel = 1'b1;
        doReset();
        applyStimulus(900, 1);
        psel = 1'b0;
        doReset();
`endif
        $display("[TB] continuous pixel ticks, two frames");
        applyStimulus(2 * H_TOT * V_TOT + 100, 1);
        $display("[TB] pixel tick every 4th clock, one frame");
        applyStimulus(H_TOT * V_TOT + 100, 4);
        repeat (3) @(negedge clk);
        if (pix_q.size() != RD_LAT - 1) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending required %0d", pix_q.size(), RD_LAT - 1);
        end
        finishRun();
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Reader end of the framebuffer path. Sprite/image writers fill an 8-bit RGB332 framebuffer, addressed 640x480 at addr = y*640 + x.
- This block generates VGA timing, issues sequential framebuffer reads in raster order, and drives sync and 4:4:4 colour to the DAC pins.
- It sits between the framebuffer RAM read port and the top-level VGA outputs.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- RD_LAT, 2, pixel ticks from rd_addr change to rd_data valid; 1 or 2 only

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel tick; all timing advances only on clk edges where pix_en=1
- rd_en  out  1  framebuffer read enable; high while the addressed pixel is visible
- rd_addr  out  19  framebuffer read address, y*H_VIS + x
- rd_data  in  8  framebuffer read data, RGB332 {R[7:5],G[4:2],B[1:0]}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  4  red channel
- green  out  4  green channel
- blue  out  4  blue channel
- active  out  1  high while the output pixel is in the visible area
- frame_start  out  1  one-clk pulse at each frame wrap

Behaviour:
- Reset: counters h=v=0, rd_addr=0, rd_en=0, red=green=blue=0, active=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive). All delay-line stages are cleared to blank/inactive.
- Reset mid-frame: restart at (0,0) immediately. No partial pixels are emitted after release.
- Counters: on a tick, h increments; at H_TOT-1 (800-1) h wraps to 0 and v increments; at V_TOT-1 (525-1) v wraps to 0. Registers hold between ticks.
- Address: rd_addr is an incremental counter, not a multiplier.
  - It increments on each tick that leaves a visible pixel.
  - It resets to 0 on the (799,524)->(0,0) wrap.
  - It holds through blanking, so (639,479) yields 307199. It never exceeds 19 bits.
- Registering: rd_addr and rd_en are registered together with h/v and describe the current counter position.
- Pipeline: hsync, vsync and active are computed from (h,v), then delayed by RD_LAT ticks. Outputs for pixel (h,v) appear RD_LAT ticks after the counters hold (h,v).
- Colour: registered on the same tick as the delayed active.
  - Visible: red={d[7:5],d[7]}, green={d[4:2],d[4]}, blue={d[1:0],d[1:0]}.
  - Blank: all colour outputs are 0.
- Sync: hsync is active for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751]. vsync is active for v in [490,491]. Both are measured at the counter stage before the delay.
- frame_start: high for exactly one clk, on the tick edge where the counters wrap to (0,0). It does not fire on reset release.
- pix_en low: all outputs hold. Continuous pix_en and pix_en every Nth clk are both legal. The RAM must return data within RD_LAT ticks.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input pattern_sel (1 bit).
  - When pattern_sel=1, visible colour comes from the delayed x as 8 vertical bars of 80 px: white, yellow, cyan, green, magenta, red, blue, black. Each channel is 4'hF or 4'h0.
  - rd_en, rd_addr and timing are unchanged.
  - pattern_sel is sampled per tick.
- Undefined: no pattern_sel port; colour always comes from rd_data.

Test Plan:
- Reset values: assert rst_n=0 mid-line -> all outputs at reset values within the same cycle. After release with pix_en=1 continuous, rd_addr counts 0,1,2…
- Line timing: pix_en=1 continuous -> hsync low for exactly 96 ticks, with the falling edge RD_LAT+656 ticks after h=0. Line period is 800 ticks; active high for 640 ticks per line.
- Frame timing: frame_start pulses every 420000 ticks. vsync is low for 1600 ticks. rd_addr=307199 at (639,479), then holds, then returns to 0 on the wrap.
- Data path:
  - RAM model returns 8'hE0 at addr 0 -> first visible output red=F, green=0, blue=0.
  - 8'h1C -> green=F.
  - 8'h03 -> blue=F.
  - 8'h92 -> red=9, green=9, blue=A.
  - Colours are 0 throughout blanking.
- Clock enable: pix_en asserted 1 of every 4 clks -> all outputs stable for 4 clks. Line period is 3200 clks; frame_start is 1 clk wide.
- Pattern (macro defined): pattern_sel=1 -> x=0..79 gives FFF, x=80 gives FF0, x=560..639 gives 000. pattern_sel=0 restores RAM data.
